// File: rtl/matrix_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the matrix operand sequencer.
//   opseq_state_t : sequencer FSM states. The encoding is shown on the front
//                   panel display, so the values are fixed.
//   op_t          : 3-bit operation code. Bit 2 set means a unary operation
//                   with no second source.
//   reg_idx_t     : matrix register index, REG_IDX_W bits wide.
//   TIMER_W       : width of the entry-abort counter and its limit.
// ----------------------------------------------------------------------------
package matrix_pkg;

    localparam int REG_IDX_W = 2;
    localparam int OP_W      = 3;
    localparam int TIMER_W   = 24;

    typedef logic [OP_W-1:0]      op_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_DST   = 3'd1,
        ST_GET_SRC_A = 3'd2,
        ST_GET_SRC_B = 3'd3,
        ST_ISSUE     = 3'd4
    } opseq_state_t;

    // Unary operations carry their flag in the top opcode bit.
    function automatic logic op_is_unary(input op_t op);
        return op[OP_W-1];
    endfunction

    // True while the operator is still pressing register buttons.
    function automatic logic in_entry(input opseq_state_t s);
        return (s == ST_GET_DST) || (s == ST_GET_SRC_A) || (s == ST_GET_SRC_B);
    endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// ----------------------------------------------------------------------------
// operand_sequencer_if
// Command bus from the operand sequencer to the matrix ALU.
//   cmd_valid : command available (master -> slave)
//   cmd_ready : ALU accepts the command (slave -> master)
//   cmd_op    : operation code
//   cmd_dst   : destination register
//   cmd_src_a : first source register
//   cmd_src_b : second source register, 0 for unary operations
// Modports: master (sequencer side), slave (ALU side).
// ----------------------------------------------------------------------------
interface operand_sequencer_if;
    import matrix_pkg::*;

    logic     cmd_valid;
    logic     cmd_ready;
    op_t      cmd_op;
    reg_idx_t cmd_dst;
    reg_idx_t cmd_src_a;
    reg_idx_t cmd_src_b;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_dst,
        output cmd_src_a,
        output cmd_src_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_dst,
        input  cmd_src_a,
        input  cmd_src_b,
        output cmd_ready
    );

endinterface

// File: rtl/operand_sequencer_timer.sv
// ----------------------------------------------------------------------------
// opseq_timer
// Entry-abort counter for the operand sequencer. Only present when the
// OPSEQ_TIMEOUT_EN macro is defined; otherwise this file is empty.
//   clk     : system clock
//   nrst    : asynchronous active-low reset
//   clr     : restart the count from zero (has priority over en)
//   en      : count this cycle
//   expired : count has reached LIMIT-1 while enabled
// Parameter LIMIT : number of enabled cycles before expiry.
// ----------------------------------------------------------------------------
`ifdef OPSEQ_TIMEOUT_EN
module opseq_timer
    import matrix_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = 24'd5_000_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = LIMIT - 24'd1;

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == LAST);

endmodule
`endif

// File: rtl/operand_sequencer.sv
// ----------------------------------------------------------------------------
// operand_sequencer
// Collects an operation and its register operands from front-panel button
// pulses and presents them as a single command to the matrix ALU.
//
// Sequence: op button (IDLE) -> dst register -> src A register ->
// src B register (binary ops only) -> ISSUE until the ALU accepts.
//
// Ports:
//   clk        : system clock
//   nrst       : asynchronous active-low reset
//   is_reg     : one-cycle pulse, register button pressed
//   reg_num    : register index, valid the cycle after is_reg
//   is_op      : one-cycle pulse, operation button pressed
//   op_code    : operation, valid with is_op
//   is_clr     : one-cycle pulse, cancel the entry in progress
//   cmd        : command bus (master modport): cmd_valid/cmd_ready handshake
//                with cmd_op, cmd_dst, cmd_src_a, cmd_src_b
//   busy       : high whenever the FSM is not in IDLE
//   state_out  : raw FSM state for the display
//   err        : one-cycle pulse when an entry is aborted by timeout
//
// Parameter TIMEOUT_CYCLES : entry-abort limit in clk cycles.
// Build option OPSEQ_TIMEOUT_EN : when defined, an entry that sees no
// register press for TIMEOUT_CYCLES cycles is abandoned and err pulses.
// When undefined, the entry states wait forever and err is tied low.
// ----------------------------------------------------------------------------
module operand_sequencer
    import matrix_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                is_reg,
    input  reg_idx_t            reg_num,
    input  logic                is_op,
    input  op_t                 op_code,
    input  logic                is_clr,
    operand_sequencer_if.master cmd,
    output logic                busy,
    output logic [2:0]          state_out,
    output logic                err
);

    opseq_state_t state_q, state_d;
    logic         reg_take_q, reg_take_d;
    op_t          cmd_op_q, cmd_op_d;
    reg_idx_t     cmd_dst_q, cmd_dst_d;
    reg_idx_t     cmd_src_a_q, cmd_src_a_d;
    reg_idx_t     cmd_src_b_q, cmd_src_b_d;
    logic         timeout_hit;

`ifdef OPSEQ_TIMEOUT_EN
    logic err_q, err_d;
    logic timer_clr;
    logic timer_en;
`endif

    // reg_num trails is_reg by a cycle, so the press is acted on one cycle late.
    assign reg_take_d = is_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and operand capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_op_d    = cmd_op_q;
        cmd_dst_d   = cmd_dst_q;
        cmd_src_a_d = cmd_src_a_q;
        cmd_src_b_d = cmd_src_b_q;
`ifdef OPSEQ_TIMEOUT_EN
        err_d       = 1'b0;
`endif

        // In every entry state a cancel beats a simultaneous register press,
        // so nothing is latched on that cycle.
        case (state_q)
            ST_IDLE: begin
                if (is_op) begin
                    cmd_op_d = op_code;
                    state_d  = ST_GET_DST;
                end
            end
            ST_GET_DST: begin
                if (is_clr) begin
                    state_d = ST_IDLE;
                end else if (reg_take_q) begin
                    cmd_dst_d = reg_num;
                    state_d   = ST_GET_SRC_A;
                end
            end
            ST_GET_SRC_A: begin
                if (is_clr) begin
                    state_d = ST_IDLE;
                end else if (reg_take_q) begin
                    cmd_src_a_d = reg_num;
                    if (op_is_unary(cmd_op_q)) begin
                        cmd_src_b_d = '0;
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d = ST_GET_SRC_B;
                    end
                end
            end
            ST_GET_SRC_B: begin
                if (is_clr) begin
                    state_d = ST_IDLE;
                end else if (reg_take_q) begin
                    cmd_src_b_d = reg_num;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd.cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A timeout only applies to an entry state with no other event this
        // cycle; a press or cancel has already moved state_d elsewhere.
        if (timeout_hit && in_entry(state_q) && (state_d == state_q)) begin
            state_d = ST_IDLE;
`ifdef OPSEQ_TIMEOUT_EN
            err_d   = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Operand / control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            reg_take_q  <= 1'b0;
            cmd_op_q    <= '0;
            cmd_dst_q   <= '0;
            cmd_src_a_q <= '0;
            cmd_src_b_q <= '0;
        end else begin
            reg_take_q  <= reg_take_d;
            cmd_op_q    <= cmd_op_d;
            cmd_dst_q   <= cmd_dst_d;
            cmd_src_a_q <= cmd_src_a_d;
            cmd_src_b_q <= cmd_src_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy          = (state_q != ST_IDLE);
        state_out     = state_q;
        cmd.cmd_valid = (state_q == ST_ISSUE);
        cmd.cmd_op    = cmd_op_q;
        cmd.cmd_dst   = cmd_dst_q;
        cmd.cmd_src_a = cmd_src_a_q;
        cmd.cmd_src_b = cmd_src_b_q;
    end

`ifdef OPSEQ_TIMEOUT_EN
    // The count restarts whenever the state changes and on every accepted
    // register press, so the limit measures idle time between presses.
    assign timer_clr = (state_d != state_q) || reg_take_q;
    assign timer_en  = in_entry(state_q);

    opseq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // The limit has no effect when the timeout is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
    import matrix_pkg::*;

    localparam logic [23:0] TMO = 24'd16;

    logic       clk     = 1'b0;
    logic       nrst    = 1'b0;
    logic       is_reg  = 1'b0;
    logic [1:0] reg_num = 2'd0;
    logic       is_op   = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic       is_clr  = 1'b0;
    logic       busy;
    logic [2:0] state_out;
    logic       err;

    operand_sequencer_if cmd_if();

    operand_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .is_reg    (is_reg),
        .reg_num   (reg_num),
        .is_op     (is_op),
        .op_code   (op_code),
        .is_clr    (is_clr),
        .cmd       (cmd_if),
        .busy      (busy),
        .state_out (state_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: an entry is a list of collected register numbers;
    // the command is complete once dst + sources are gathered.
    // ------------------------------------------------------------------
    bit         m_active = 0;
    bit         m_issue  = 0;
    bit         m_take   = 0;
    bit         m_err    = 0;
    bit         take_now = 0;
    int         m_n      = 0;
    int         m_wait   = 0;
    logic [2:0] m_op     = 3'd0;
    logic [1:0] m_f [3]  = '{2'd0, 2'd0, 2'd0};

    function automatic int needed(input logic [2:0] op);
        return op[2] ? 2 : 3;
    endfunction

    function automatic int exp_state();
        if (!m_active) return 0;
        if (m_issue)   return 4;
        return 1 + m_n;
    endfunction

    initial forever begin
        @(posedge clk or negedge nrst);
        if (!nrst) begin
            m_active = 0; m_issue = 0; m_take = 0; m_err = 0;
            m_n = 0; m_wait = 0; m_op = 3'd0;
            m_f = '{2'd0, 2'd0, 2'd0};
        end else begin
            take_now = m_take;
            m_take   = is_reg;
            m_err    = 0;
            if (!m_active) begin
                if (is_op) begin
                    m_active = 1; m_issue = 0; m_op = op_code; m_n = 0; m_wait = 0;
                end
            end else if (m_issue) begin
                if (cmd_if.cmd_ready) begin
                    m_active = 0; m_issue = 0;
                end
            end else if (is_clr) begin
                m_active = 0;
            end else if (take_now) begin
                m_f[m_n] = reg_num;
                m_n++;
                m_wait = 0;
                if (m_n == needed(m_op)) begin
                    m_issue = 1;
                    if (m_op[2]) m_f[2] = 2'd0;
                end
            end else begin
`ifdef OPSEQ_TIMEOUT_EN
                if (m_wait == int'(TMO) - 1) begin
                    m_active = 0; m_err = 1;
                end else begin
                    m_wait++;
                end
`endif
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("state_out", state_out, exp_state());
        chk("busy", busy, m_active);
        chk("cmd_valid", cmd_if.cmd_valid, m_active && m_issue);
        chk("err", err, m_err);
        if (m_active && m_issue) begin
            chk("cmd_op", cmd_if.cmd_op, m_op);
            chk("cmd_dst", cmd_if.cmd_dst, m_f[0]);
            chk("cmd_src_a", cmd_if.cmd_src_a, m_f[1]);
            chk("cmd_src_b", cmd_if.cmd_src_b, m_f[2]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic press_op(input logic [2:0] op);
        is_op   = 1'b1;
        op_code = op;
        @(negedge clk);
        is_op   = 1'b0;
        op_code = ~op;
    endtask

    task automatic press_reg(input logic [1:0] r, input logic clr);
        is_reg  = 1'b1;
        reg_num = ~r;
        @(negedge clk);
        is_reg  = 1'b0;
        reg_num = r;
        is_clr  = clr;
        @(negedge clk);
        is_clr  = 1'b0;
        reg_num = ~r;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, cmd_if.cmd_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_op"}, cmd_if.cmd_op, 0);
        chk({tag, "_dst"}, cmd_if.cmd_dst, 0);
        chk({tag, "_src_a"}, cmd_if.cmd_src_a, 0);
        chk({tag, "_src_b"}, cmd_if.cmd_src_b, 0);
    endtask

    initial begin
        cmd_if.cmd_ready = 1'b0;
        #1;
        chk_all_zero("rst_init");
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Binary op 1: dst 2, a 0, b 1; valid two cycles after the last is_reg
        press_op(3'b001);
        chk("bin_get_dst", state_out, 1);
        press_reg(2'd2, 1'b0);
        chk("bin_get_a", state_out, 2);
        press_reg(2'd0, 1'b0);
        chk("bin_get_b", state_out, 3);
        is_reg  = 1'b1;
        reg_num = 2'd2;
        @(negedge clk);
        is_reg  = 1'b0;
        reg_num = 2'd1;
        chk("bin_lat1_valid", cmd_if.cmd_valid, 0);
        @(negedge clk);
        reg_num = 2'd3;
        chk("bin_lat2_valid", cmd_if.cmd_valid, 1);
        chk("bin_op", cmd_if.cmd_op, 1);
        chk("bin_dst", cmd_if.cmd_dst, 2);
        chk("bin_a", cmd_if.cmd_src_a, 0);
        chk("bin_b", cmd_if.cmd_src_b, 1);
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
        chk("bin_done_valid", cmd_if.cmd_valid, 0);
        chk("bin_done_state", state_out, 0);

        // Unary op 4: dst 3, a 1, ISSUE straight from GET_SRC_A, then backpressure
        press_op(3'b100);
        press_reg(2'd3, 1'b0);
        chk("un_get_a", state_out, 2);
        press_reg(2'd1, 1'b0);
        chk("un_issue", state_out, 4);
        for (int i = 0; i < 10; i++) begin
            is_clr = (i == 2);
            is_op  = (i == 5);
            op_code = 3'b011;
            @(negedge clk);
            chk("bp_valid", cmd_if.cmd_valid, 1);
            chk("bp_op", cmd_if.cmd_op, 4);
            chk("bp_dst", cmd_if.cmd_dst, 3);
            chk("bp_a", cmd_if.cmd_src_a, 1);
            chk("bp_b", cmd_if.cmd_src_b, 0);
        end
        is_clr = 1'b0;
        is_op  = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
        chk("bp_done_state", state_out, 0);
        chk("bp_done_valid", cmd_if.cmd_valid, 0);

        // Ignored presses, then cancel colliding with the src A press
        press_reg(2'd2, 1'b0);
        chk("idle_reg_ignored", state_out, 0);
        press_op(3'b010);
        press_op(3'b111);
        chk("op_ignored_state", state_out, 1);
        press_reg(2'd1, 1'b0);
        press_reg(2'd2, 1'b1);
        chk("clr_state", state_out, 0);
        chk("clr_src_a_kept", cmd_if.cmd_src_a, 1);
        chk("clr_op_kept", cmd_if.cmd_op, 2);
        repeat (3) @(negedge clk);
        chk("clr_no_valid", cmd_if.cmd_valid, 0);

        // Idle in GET_DST
        press_op(3'b011);
        chk("tmo_enter", state_out, 1);
`ifdef OPSEQ_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("tmo_before_state", state_out, 1);
        chk("tmo_before_err", err, 0);
        @(negedge clk);
        chk("tmo_state", state_out, 0);
        chk("tmo_err", err, 1);
        @(negedge clk);
        chk("tmo_err_pulse", err, 0);
`else
        repeat (100) @(negedge clk);
        chk("wait_state", state_out, 1);
        chk("wait_err", err, 0);
        is_clr = 1'b1;
        @(negedge clk);
        is_clr = 1'b0;
        chk("wait_clr_state", state_out, 0);
`endif

        // Reset during ISSUE
        press_op(3'b100);
        press_reg(2'd0, 1'b0);
        press_reg(2'd2, 1'b0);
        chk("rst_pre_valid", cmd_if.cmd_valid, 1);
        chk("rst_pre_a", cmd_if.cmd_src_a, 2);
        #2;
        nrst = 1'b0;
        #1;
        chk_all_zero("rst_issue");
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_post_valid", cmd_if.cmd_valid, 0);
        chk("rst_post_state", state_out, 0);

        // Binary op with the ALU already ready: valid for exactly one cycle
        cmd_if.cmd_ready = 1'b1;
        press_op(3'b000);
        press_reg(2'd1, 1'b0);
        press_reg(2'd2, 1'b0);
        press_reg(2'd3, 1'b0);
        chk("rdy_valid", cmd_if.cmd_valid, 1);
        chk("rdy_b", cmd_if.cmd_src_b, 3);
        @(negedge clk);
        chk("rdy_done_state", state_out, 0);
        cmd_if.cmd_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
